// File: rtl/pc_pkg.sv
// Shared defaults and the per-cycle action encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned PC_RESET = 0;

    typedef enum logic [2:0] {
        HOLD,
        SRC,
        RET,
        ADV,
        RET_UNF
    } pc_act_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
// Sticky overflow/underflow flags are cleared only by reset.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(RAS_DEPTH):0]   o_count,
    output logic                         o_ovf,
    output logic                         o_unf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]    r_head;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             w_full;
    logic             w_empty;
    logic [PW-1:0]    w_top_idx;

    assign w_full    = (r_count == CW'(RAS_DEPTH));
    assign w_empty   = (r_count == '0);
    // r_head is the next free slot; when full it also addresses the oldest entry.
    assign w_top_idx = r_head - PW'(1);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_head] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (i_push) begin
            r_head <= r_head + PW'(1);
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop) begin
            if (w_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_head  <= w_top_idx;
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_top   = r_mem[w_top_idx];
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with prioritised write channels, auto-advance and a return-address stack.
// Optional alignment checking is enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH,
    parameter int unsigned NSRC      = 3,
    parameter int unsigned STEP      = PC_STEP,
    parameter int unsigned RESET_PC  = PC_RESET,
    parameter int unsigned RAS_DEPTH = 4,
    localparam int unsigned GW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NSRC-1:0]              src_wren,
    input  logic [NSRC*WIDTH-1:0]        src_wdata,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         adv,
    input  logic                         stall,
    output logic [WIDTH-1:0]             pc,
    output logic [GW-1:0]                grant_idx,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic                         misalign
);

    logic [WIDTH-1:0]           r_pc;
    logic [GW-1:0]              r_grant;
    logic                       w_src_hit;
    logic [GW-1:0]              w_src_idx;
    logic [WIDTH-1:0]           w_src_data;
    pc_act_t                    w_act;
    logic [WIDTH-1:0]           w_pc_nxt;
    logic [GW-1:0]              w_grant_nxt;
    logic [WIDTH-1:0]           w_ras_top;
    logic [$clog2(RAS_DEPTH):0] w_ras_count;
    logic                       w_push;
    logic                       w_pop;

    always_comb begin
        w_src_hit  = 1'b0;
        w_src_idx  = '0;
        w_src_data = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (src_wren[i] && !w_src_hit) begin
                w_src_hit  = 1'b1;
                w_src_idx  = GW'(i);
                w_src_data = src_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // An empty-stack return still consumes the cycle, so adv is suppressed.
    always_comb begin
        w_act = HOLD;
        if (w_src_hit) begin
            w_act = SRC;
        end else if (ret && !stall) begin
            w_act = (w_ras_count == '0) ? RET_UNF : RET;
        end else if (adv && !stall) begin
            w_act = ADV;
        end
    end

    always_comb begin
        w_pc_nxt    = r_pc;
        w_grant_nxt = r_grant;
        case (w_act)
            SRC: begin
                w_pc_nxt    = w_src_data;
                w_grant_nxt = w_src_idx;
            end
            RET:     w_pc_nxt = w_ras_top;
            ADV:     w_pc_nxt = r_pc + WIDTH'(STEP);
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= WIDTH'(RESET_PC);
            r_grant <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign w_push = (w_act == SRC) && call;
    assign w_pop  = (w_act == RET) || (w_act == RET_UNF);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_pc + WIDTH'(STEP)),
        .i_pop       (w_pop),
        .o_top       (w_ras_top),
        .o_count     (w_ras_count),
        .o_ovf       (ras_ovf),
        .o_unf       (ras_unf)
    );

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_mis_hit;

    assign w_mis_hit = ((w_act == SRC) || (w_act == RET)) &&
                       ((w_pc_nxt & WIDTH'(STEP - 1)) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_mis_hit) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    assign pc        = r_pc;
    assign grant_idx = r_grant;
    assign ras_count = w_ras_count;

endmodule
